shift_reg_param: RTL and testbench

Parametrised LED shift/rotate engine for the board-level LED labs. An internal tick divider paces the operations. Four push-button keys select serial data, operating mode, clear and pause. The `W`-bit pattern drives the LED bank directly. The divider state is exported for the bench and for neighbouring blocks.

---
 rtl/shift_reg_param.sv | 133 +++++++++++++
 tb/tb_shift_reg_param.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_param.sv
// ---------------------------------------------------------------------------
// shift_reg_param
//
// LED shift/rotate engine. A free-running tick divider produces a one-cycle
// shift strobe every DIV unpaused cycles; on each strobe the W-bit pattern is
// shifted or rotated according to the current mode. Four raw push-button
// keys are synchronised and edge-detected on chip.
//
// Ports:
//   clk   in   1    system clock, all state on its rising edge
//   rst   in   1    asynchronous active-low reset
//   key   in   4    raw active-high buttons:
//                     [0] serial data, [1] mode advance (rising edge),
//                     [2] clear (rising edge), [3] pause (level)
//   led   out  W    current pattern register
//   cnt   out  CW   tick divider value (CW = max(1, $clog2(DIV)))
//   en    out  1    one-cycle shift strobe
//   mode  out  2    current mode: 0 SHIFT_L, 1 SHIFT_R, 2 ROT_L, 3 ROT_R
//
// The mode output is the mode FSM state register itself, so the FSM state
// is always observable from outside the block.
// ---------------------------------------------------------------------------
module shift_reg_param #(
    parameter int W   = 8,
    parameter int DIV = 4,
    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    key,
    output logic [W-1:0]  led,
    output logic [CW-1:0] cnt,
    output logic          en,
    output logic [1:0]    mode
);

    typedef enum logic [1:0] {
        SHIFT_L = 2'd0,
        SHIFT_R = 2'd1,
        ROT_L   = 2'd2,
        ROT_R   = 2'd3
    } mode_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    // Two-flop synchroniser for every key.
    logic [3:0]    key_m_q;     // first (metastability) stage
    logic [3:0]    key_s_q;     // synchronised key levels
    // Edge-detect stage; only the two edge-triggered keys (mode, clear)
    // need a delayed copy.
    logic [2:1]    key_d_q;

    logic [W-1:0]  led_q,  led_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    mode_t         mode_q, mode_d;

    logic          rise_mode;
    logic          rise_clr;
    logic          pause;
    logic          data_in;
    logic          en_c;

    always_comb begin
        rise_mode = key_s_q[1] & ~key_d_q[1];
        rise_clr  = key_s_q[2] & ~key_d_q[2];
        pause     = key_s_q[3];
        data_in   = key_s_q[0];

        // Decoded purely from flops so the strobe is glitch-free and exactly
        // one cycle wide.
        en_c = (cnt_q == CNT_MAX) & ~pause;

        // Divider: clear wins over pause, pause holds, otherwise wrap count.
        cnt_d = cnt_q;
        if (rise_clr) begin
            cnt_d = '0;
        end else if (!pause) begin
            cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
        end

        // Pattern: clear wins over a coincident shift. The shift always uses
        // the registered (old) mode, so a mode change on a strobe cycle only
        // affects the following tick.
        led_d = led_q;
        if (rise_clr) begin
            led_d = '0;
        end else if (en_c) begin
            case (mode_q)
                SHIFT_L: led_d = {led_q[W-2:0], data_in};
                SHIFT_R: led_d = {data_in, led_q[W-1:1]};
                ROT_L:   led_d = {led_q[W-2:0], led_q[W-1]};
                ROT_R:   led_d = {led_q[0], led_q[W-1:1]};
                default: led_d = led_q;
            endcase
        end

        // Mode FSM: cyclic advance on each mode-key rising edge only.
        mode_d = mode_q;
        if (rise_mode) begin
            case (mode_q)
                SHIFT_L: mode_d = SHIFT_R;
                SHIFT_R: mode_d = ROT_L;
                ROT_L:   mode_d = ROT_R;
                ROT_R:   mode_d = SHIFT_L;
                default: mode_d = SHIFT_L;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_m_q <= '0;
            key_s_q <= '0;
            key_d_q <= '0;
            led_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= SHIFT_L;
        end else begin
            key_m_q <= key;
            key_s_q <= key_m_q;
            key_d_q <= key_s_q[2:1];
            led_q   <= led_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign led  = led_q;
    assign cnt  = cnt_q;
    assign en   = en_c;
    assign mode = mode_q;

endmodule

// File: tb/tb_shift_reg_param.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_param
//
// Directed bench for shift_reg_param with W = 8, DIV = 4. Inputs are driven
// and outputs sampled on the falling clock edge; each scenario task does its
// own comparisons against hand-computed values.
// ---------------------------------------------------------------------------
module tb_shift_reg_param;

    localparam int W   = 8;
    localparam int DIV = 4;
    localparam int CW  = 2;

    logic          clk;
    logic          rst;
    logic [3:0]    key;
    logic [W-1:0]  led;
    logic [CW-1:0] cnt;
    logic          en;
    logic [1:0]    mode;

    int n_cmp;
    int n_fail;

    shift_reg_param #(.W(W), .DIV(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .key  (key),
        .led  (led),
        .cnt  (cnt),
        .en   (en),
        .mode (mode)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Advance one full cycle: through the rising edge to the next falling one.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    // Step until en is seen high (bounded); returns the number of steps.
    task automatic wait_en(output int n);
        n = 0;
        while (en !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n_cmp++;
        if (en !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_en_timeout: en=%b after %0d cycles, want 1", en, n);
        end
    endtask

    task automatic chk_led(input string name, input logic [W-1:0] exp);
        n_cmp++;
        if (led !== exp) begin
            n_fail++;
            $display("FAIL %s: led=%h want %h", name, led, exp);
        end
    endtask

    task automatic chk_cnt_en(input string name, input logic [CW-1:0] exp_cnt,
                              input logic exp_en);
        n_cmp++;
        if (cnt !== exp_cnt || en !== exp_en) begin
            n_fail++;
            $display("FAIL %s: cnt=%0d en=%b want cnt=%0d en=%b",
                     name, cnt, en, exp_cnt, exp_en);
        end
    endtask

    task automatic chk_mode(input string name, input logic [1:0] exp);
        n_cmp++;
        if (mode !== exp) begin
            n_fail++;
            $display("FAIL %s: mode=%0d want %0d", name, mode, exp);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        @(negedge clk);
        chk_led("reset_led", 8'h00);
        chk_cnt_en("reset_cnt_en", 2'd0, 1'b0);
        chk_mode("reset_mode", 2'd0);
        // Data key high during reset: must not disturb anything yet.
        key[0] = 1'b1;
        step();
        chk_led("reset_hold_led", 8'h00);
        chk_cnt_en("reset_hold_cnt_en", 2'd0, 1'b0);
        rst = 1'b1;
        // First strobe comes DIV-1 edges after release.
        step();
        chk_cnt_en("first_tick_c1", 2'd1, 1'b0);
        step();
        chk_cnt_en("first_tick_c2", 2'd2, 1'b0);
        step();
        chk_cnt_en("first_tick_c3", 2'd3, 1'b1);
        chk_led("first_tick_led", 8'h00);
    endtask

    task automatic test_fill();
        logic [W-1:0] exp;
        int n;
        step();
        exp = 8'h01;
        chk_led("fill_0", exp);
        for (int i = 1; i < 8; i++) begin
            wait_en(n);
            n_cmp++;
            if (n != DIV - 1) begin
                n_fail++;
                $display("FAIL fill_spacing: %0d cycles want %0d", n, DIV - 1);
            end
            step();
            exp = {exp[W-2:0], 1'b1};
            chk_led($sformatf("fill_%0d", i), exp);
        end
        wait_en(n);
        step();
        chk_led("fill_sat", 8'hFF);
    endtask

    task automatic test_mode_drain();
        logic [W-1:0] exp;
        int n;
        key[1] = 1'b1;
        steps(3);
        chk_mode("drain_mode1", 2'd1);
        key[1] = 1'b0;
        key[0] = 1'b0;
        steps(2);
        exp = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            wait_en(n);
            step();
            exp = exp >> 1;
            chk_led($sformatf("drain_%0d", i), exp);
        end
    endtask

    task automatic test_rotate();
        logic [W-1:0] exp;
        int n;
        // Load 80 with one SHIFT_R tick of a 1, then ROT_L brings it to 01.
        key[0] = 1'b1;
        steps(2);
        wait_en(n);
        key[0] = 1'b0;
        step();
        chk_led("rot_load80", 8'h80);
        key[1] = 1'b1;
        steps(3);
        chk_mode("rot_mode2", 2'd2);
        chk_cnt_en("rot_en_after_adv", 2'd3, 1'b1);
        key[1] = 1'b0;
        step();
        exp = 8'h01;
        chk_led("rotl_wrap_in", exp);
        for (int i = 0; i < 8; i++) begin
            key[0] = ~key[0];
            wait_en(n);
            step();
            exp = {exp[W-2:0], exp[W-1]};
            chk_led($sformatf("rotl_%0d", i), exp);
        end
        key[1] = 1'b1;
        steps(3);
        chk_mode("rot_mode3", 2'd3);
        key[1] = 1'b0;
        step();
        exp = 8'h80;
        chk_led("rotr_wrap", exp);
        for (int i = 0; i < 2; i++) begin
            key[0] = ~key[0];
            wait_en(n);
            step();
            exp = {exp[0], exp[W-1:1]};
            chk_led($sformatf("rotr_%0d", i), exp);
        end
        // Mode advance landing on a strobe: shift uses the old mode (ROT_R).
        step();
        key[1] = 1'b1;
        steps(2);
        chk_cnt_en("adv_coinc_en", 2'd3, 1'b1);
        chk_mode("adv_coinc_old", 2'd3);
        key[1] = 1'b0;
        step();
        chk_led("adv_coinc_led", 8'h10);
        chk_mode("adv_coinc_new", 2'd0);
    endtask

    task automatic test_clear();
        logic [W-1:0] exp;
        int n;
        key[0] = 1'b1;
        key[2] = 1'b1;
        steps(3);
        chk_led("clr_led", 8'h00);
        chk_cnt_en("clr_cnt", 2'd0, 1'b0);
        key[2] = 1'b0;
        exp = 8'h00;
        for (int i = 0; i < 4; i++) begin
            wait_en(n);
            step();
            exp = {exp[W-2:0], 1'b1};
        end
        chk_led("clr_load0f", 8'h0F);
        // Clear landing on a strobe: clear wins.
        step();
        key[2] = 1'b1;
        steps(2);
        chk_cnt_en("clr_coinc_en", 2'd3, 1'b1);
        chk_led("clr_coinc_pre", exp);
        step();
        chk_led("clr_coinc_led", 8'h00);
        chk_cnt_en("clr_coinc_cnt", 2'd0, 1'b0);
        key[2] = 1'b0;
        wait_en(n);
        n_cmp++;
        if (n != 3) begin
            n_fail++;
            $display("FAIL clr_next_en: %0d cycles want 3", n);
        end
        step();
        chk_led("clr_after", 8'h01);
    endtask

    task automatic test_pause();
        int n;
        wait_en(n);
        key[3] = 1'b1;
        steps(2);
        chk_cnt_en("pause_freeze", 2'd1, 1'b0);
        chk_led("pause_led", 8'h03);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_cnt_en($sformatf("pause_hold_%0d", i), 2'd1, 1'b0);
        end
        chk_led("pause_led_hold", 8'h03);
        key[3] = 1'b0;
        step();
        chk_cnt_en("unpause_r1", 2'd1, 1'b0);
        step();
        chk_cnt_en("unpause_r2", 2'd1, 1'b0);
        step();
        chk_cnt_en("unpause_c2", 2'd2, 1'b0);
        step();
        chk_cnt_en("unpause_c3", 2'd3, 1'b1);
        step();
        chk_led("unpause_shift", 8'h07);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            key[1] = 1'b1;
            steps(3);
            key[1] = 1'b0;
            steps(2);
        end
        chk_mode("mid_pre_mode3", 2'd3);
        // Pending edges on mode and clear while reset is asserted.
        key[1] = 1'b1;
        key[2] = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk_led("mid_rst_led", 8'h00);
        chk_cnt_en("mid_rst_cnt_en", 2'd0, 1'b0);
        chk_mode("mid_rst_mode", 2'd0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_led($sformatf("mid_hold_led_%0d", i), 8'h00);
            chk_cnt_en($sformatf("mid_hold_cnt_%0d", i), 2'd0, 1'b0);
            chk_mode($sformatf("mid_hold_mode_%0d", i), 2'd0);
        end
        rst = 1'b1;
        key = 4'b0000;
        step();
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        key    = 4'b0000;
        test_reset();
        test_fill();
        test_mode_drain();
        test_rotate();
        test_clear();
        test_pause();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

endmodule
